// File: rtl/serial_cmp_pkg.sv
// Shared types and result encodings for the
// bit-serial magnitude comparator.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EQ   = 2'd1,
    GT   = 2'd2,
    LT   = 2'd3
  } state_t;

  localparam logic [2:0] RES_LT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_GT   = 3'b001;
  localparam logic [2:0] RES_NONE = 3'b000;

  function automatic logic [2:0] state_res(
    input state_t s
  );
    logic [2:0] r;
    r = RES_NONE;
    unique case (s)
      IDLE: r = RES_NONE;
      EQ:   r = RES_EQ;
      GT:   r = RES_GT;
      LT:   r = RES_LT;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/serial_cmp_fsm_frame_counter.sv
// Mod-WORD_LEN bit counter marking the LSB
// edge of each back-to-back word frame.
module frame_counter #(
  parameter int WORD_LEN = 3,
  parameter int CW = $clog2(WORD_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [CW-1:0] cnt,
  output logic          first_bit
);

  localparam logic [CW-1:0] LAST =
    CW'(WORD_LEN - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign first_bit = (cnt == '0);

endmodule

// File: rtl/serial_cmp_fsm.sv
// Bit-serial LSB-first unsigned comparator with
// Moore one-hot {M,R,W} = {A<B, A=B, A>B}.
module serial_cmp_fsm
  import serial_cmp_pkg::*;
#(
  parameter int WORD_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic A,
  input  logic B,
  output logic M,
  output logic R,
  output logic W
);

  localparam int CW = $clog2(WORD_LEN);

  logic [CW-1:0] cnt;
  logic          first_bit;
  logic          new_word;
  state_t        state_q;
  state_t        state_d;
  logic [2:0]    res;

  frame_counter #(
    .WORD_LEN (WORD_LEN),
    .CW       (CW)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .cnt       (cnt),
    .first_bit (first_bit)
  );

  // IDLE only follows reset, so it always starts a word
  assign new_word = first_bit | (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    if (new_word) begin
      unique case (1'b1)
        (A & ~B): state_d = GT;
        (~A & B): state_d = LT;
        default:  state_d = EQ;
      endcase
    end else if ((|cnt) && (A != B)) begin
      state_d = A ? GT : LT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign res = state_res(state_q);
  assign {M, R, W} = res;

endmodule

// File: tb/tb_serial_cmp_fsm.sv
// Directed and random checks for serial_cmp_fsm
// with WORD_LEN=3, LSB-first framing.
module tb_serial_cmp_fsm;

  logic clk;
  logic rst_n;
  logic A;
  logic B;
  logic M;
  logic R;
  logic W;

  int total;
  int bad;

  serial_cmp_fsm #(.WORD_LEN(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .M     (M),
    .R     (R),
    .W     (W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] cmp_ref(
    input logic [2:0] a,
    input logic [2:0] b
  );
    if (a > b) return 3'b001;
    if (a < b) return 3'b100;
    return 3'b010;
  endfunction

  task automatic send_bit(input logic a, input logic b);
    @(negedge clk);
    A = a;
    B = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(
    input  logic [2:0] a,
    input  logic [2:0] b,
    output logic [2:0] res
  );
    for (int k = 0; k < 3; k++) send_bit(a[k], b[k]);
    res = {M, R, W};
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      A = 1'($urandom);
      B = 1'($urandom);
      @(posedge clk);
      #1;
      total++;
      if ({M, R, W} !== 3'b000) begin
        bad++;
        $display("FAIL reset_hold got=%b want=000", {M, R, W});
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_walk;
    logic [2:0] want [3];
    logic [2:0] a;
    logic [2:0] b;
    want[0] = 3'b010;
    want[1] = 3'b100;
    want[2] = 3'b001;
    a = 3'd5;
    b = 3'd3;
    for (int k = 0; k < 3; k++) begin
      send_bit(a[k], b[k]);
      total++;
      if ({M, R, W} !== want[k]) begin
        bad++;
        $display("FAIL walk_5_3 edge=%0d got=%b want=%b",
                 k, {M, R, W}, want[k]);
      end
    end
  endtask

  task automatic test_words;
    logic [2:0] va [6];
    logic [2:0] vb [6];
    logic [2:0] vw [6];
    logic [2:0] got;
    va[0] = 3'd2; vb[0] = 3'd6; vw[0] = 3'b100;
    va[1] = 3'd4; vb[1] = 3'd4; vw[1] = 3'b010;
    va[2] = 3'd0; vb[2] = 3'd0; vw[2] = 3'b010;
    va[3] = 3'd7; vb[3] = 3'd0; vw[3] = 3'b001;
    va[4] = 3'd1; vb[4] = 3'd0; vw[4] = 3'b001;
    va[5] = 3'd3; vb[5] = 3'd5; vw[5] = 3'b100;
    for (int i = 0; i < 6; i++) begin
      send_word(va[i], vb[i], got);
      total++;
      if (got !== vw[i]) begin
        bad++;
        $display("FAIL word a=%0d b=%0d got=%b want=%b",
                 va[i], vb[i], got, vw[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] got;
    send_word(3'd7, 3'd0, got);
    total++;
    if (got !== 3'b001) begin
      bad++;
      $display("FAIL b2b_first got=%b want=001", got);
    end
    send_word(3'd0, 3'd7, got);
    total++;
    if (got !== 3'b100) begin
      bad++;
      $display("FAIL b2b_second got=%b want=100", got);
    end
  endtask

  task automatic test_mid_reset;
    logic [2:0] got;
    send_bit(1'b0, 1'b1);
    total++;
    if ({M, R, W} !== 3'b100) begin
      bad++;
      $display("FAIL mid_bit0 got=%b want=100", {M, R, W});
    end
    send_bit(1'b1, 1'b0);
    total++;
    if ({M, R, W} !== 3'b001) begin
      bad++;
      $display("FAIL mid_bit1 got=%b want=001", {M, R, W});
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({M, R, W} !== 3'b000) begin
      bad++;
      $display("FAIL async_rst got=%b want=000", {M, R, W});
    end
    for (int i = 0; i < 2; i++) begin
      A = 1'b1;
      B = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if ({M, R, W} !== 3'b000) begin
        bad++;
        $display("FAIL rst_hold got=%b want=000", {M, R, W});
      end
    end
    rst_n = 1'b1;
    send_word(3'd3, 3'd3, got);
    total++;
    if (got !== 3'b010) begin
      bad++;
      $display("FAIL post_rst got=%b want=010", got);
    end
  endtask

  task automatic test_random;
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] got;
    logic [2:0] want;
    for (int i = 0; i < 64; i++) begin
      a = 3'($urandom_range(0, 7));
      b = 3'($urandom_range(0, 7));
      want = cmp_ref(a, b);
      send_word(a, b, got);
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL rand a=%0d b=%0d got=%b want=%b",
                 a, b, got, want);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    A = 1'b0;
    B = 1'b0;
    rst_n = 1'b0;
    test_reset;
    test_walk;
    test_words;
    test_back_to_back;
    test_mid_reset;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
